// File: rtl/error_response_decoder_if.sv
// Byte-stream receive channel for the error response decoder.
// The master presents bytes with valid/last; the slave answers with ready.
interface error_response_decoder_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_last;
  logic       rx_ready;

  modport master (output rx_byte, output rx_valid, output rx_last, input  rx_ready);
  modport slave  (input  rx_byte, input  rx_valid, input  rx_last, output rx_ready);
endinterface

// File: rtl/error_response_decoder.sv
// Decodes a 4-byte response header (version, command, param1, param2) and
// classifies it as an error response, a malformed message or a timeout.
module error_response_decoder #(
  parameter logic [7:0] PROTOCOL_VERSION = 8'h01,
  parameter logic [7:0] ERROR_RESP_CMD   = 8'h7F,
  parameter int         TIMEOUT_CYCLES   = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Enable,
  error_response_decoder_if.slave rx,
  output logic                   decode_valid,
  output logic                   is_error_resp,
  output logic                   malformed,
  output logic                   timeout,
  output logic                   Error_Invalid_Request,
  output logic                   Error_Unsupported_Protocol,
  output logic                   Error_Busy,
  output logic                   Error_Unspecified,
  output logic                   Error_Unknown_Code,
  output logic [7:0]             param1,
  output logic [7:0]             param2
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, B1, B2, B3, DRAIN, REPORT} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] idle_cnt, cnt_next;

  // Per-message capture; reinitialised by the first byte of every message.
  logic       ver_bad_q, ver_bad_d;
  logic       not_err_q, not_err_d;
  logic       payload_q, payload_d;
  logic [7:0] p1_q, p1_d;
  logic [7:0] p2_q, p2_d;

  logic       ready, accept, in_msg, timeout_hit;
  logic       short_msg, to_evt, hdr_done, report_go;
  logic       res_malformed, res_is_err;
  logic [4:0] res_err, err_q;

  // Held low while reset is asserted so no byte appears taken during reset.
  assign ready       = Enable && !reset && (state != REPORT);
  assign rx.rx_ready = ready;
  assign accept      = rx.rx_valid && ready;
  assign in_msg      = state inside {B1, B2, B3, DRAIN};
  assign timeout_hit = (idle_cnt == CNT_LAST);

  // NOTE: every signal gets a default at the top of the block, so no path
  // through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    ver_bad_d  = ver_bad_q;
    not_err_d  = not_err_q;
    payload_d  = payload_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    short_msg  = 1'b0;
    to_evt     = 1'b0;
    hdr_done   = 1'b0;

    if (accept) begin
      case (state)
        IDLE: begin
          ver_bad_d = (rx.rx_byte != PROTOCOL_VERSION);
          not_err_d = 1'b1;
          payload_d = 1'b0;
          p1_d      = 8'h00;
          p2_d      = 8'h00;
        end
        B1:      not_err_d = (rx.rx_byte != ERROR_RESP_CMD);
        B2:      p1_d      = rx.rx_byte;
        B3:      p2_d      = rx.rx_byte;
        default: ;
      endcase
    end

    if (!Enable) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            next_state = rx.rx_last ? REPORT : B1;
            short_msg  = rx.rx_last;
          end
        end
        B1, B2: begin
          if (accept) begin
            next_state = rx.rx_last ? REPORT : ((state == B1) ? B2 : B3);
            short_msg  = rx.rx_last;
          end else if (timeout_hit) begin
            next_state = REPORT;
            to_evt     = 1'b1;
          end
        end
        B3: begin
          if (accept) begin
            hdr_done = rx.rx_last;
            if (rx.rx_last) begin
              next_state = REPORT;
            end else begin
              next_state = DRAIN;
              payload_d  = 1'b1;
            end
          end else if (timeout_hit) begin
            next_state = REPORT;
            to_evt     = 1'b1;
          end
        end
        DRAIN: begin
          if (accept) begin
            if (rx.rx_last) begin
              next_state = REPORT;
              hdr_done   = 1'b1;
            end
          end else if (timeout_hit) begin
            next_state = REPORT;
            to_evt     = 1'b1;
            hdr_done   = 1'b1;
          end
        end
        REPORT:  next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end

    report_go     = (next_state == REPORT);
    res_malformed = short_msg || to_evt || ver_bad_d || payload_d;
    res_is_err    = hdr_done && !res_malformed && !not_err_d;

    res_err = 5'b00000;
    if (res_is_err) begin
      case (p1_d)
        8'h01:   res_err = 5'b10000;
        8'h02:   res_err = 5'b01000;
        8'h03:   res_err = 5'b00100;
        8'h04:   res_err = 5'b00010;
        default: res_err = 5'b00001;
      endcase
    end

    cnt_next = (Enable && in_msg && !accept && (next_state == state))
             ? idle_cnt + CNT_W'(1) : '0;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      idle_cnt      <= '0;
      ver_bad_q     <= 1'b0;
      not_err_q     <= 1'b0;
      payload_q     <= 1'b0;
      p1_q          <= 8'h00;
      p2_q          <= 8'h00;
      is_error_resp <= 1'b0;
      malformed     <= 1'b0;
      timeout       <= 1'b0;
      err_q         <= 5'b00000;
      param1        <= 8'h00;
      param2        <= 8'h00;
    end else begin
      state     <= next_state;
      idle_cnt  <= cnt_next;
      ver_bad_q <= ver_bad_d;
      not_err_q <= not_err_d;
      payload_q <= payload_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      if (report_go) begin
        is_error_resp <= res_is_err;
        malformed     <= res_malformed;
        timeout       <= to_evt;
        err_q         <= res_err;
        param1        <= p1_d;
        param2        <= p2_d;
      end
    end
  end

  assign decode_valid               = (state == REPORT);
  assign Error_Invalid_Request      = err_q[4];
  assign Error_Unsupported_Protocol = err_q[3];
  assign Error_Busy                 = err_q[2];
  assign Error_Unspecified          = err_q[1];
  assign Error_Unknown_Code         = err_q[0];

endmodule

// File: tb/tb_error_response_decoder.sv
// Directed bench for error_response_decoder; result vector packs
// {decode_valid, is_error_resp, malformed, timeout, 5 error flags, param1, param2}.
module tb_error_response_decoder;

  logic clk = 1'b0;
  logic reset;
  logic Enable;
  logic decode_valid, is_error_resp, malformed, timeout;
  logic Error_Invalid_Request, Error_Unsupported_Protocol, Error_Busy;
  logic Error_Unspecified, Error_Unknown_Code;
  logic [7:0] param1, param2;

  int n_checks = 0;
  int n_fail   = 0;
  bit not_ready_seen;
  bit early_dv;

  error_response_decoder_if rx_if ();

  error_response_decoder #(
    .PROTOCOL_VERSION(8'h01),
    .ERROR_RESP_CMD  (8'h7F),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .Enable                    (Enable),
    .rx                        (rx_if.slave),
    .decode_valid              (decode_valid),
    .is_error_resp             (is_error_resp),
    .malformed                 (malformed),
    .timeout                   (timeout),
    .Error_Invalid_Request     (Error_Invalid_Request),
    .Error_Unsupported_Protocol(Error_Unsupported_Protocol),
    .Error_Busy                (Error_Busy),
    .Error_Unspecified         (Error_Unspecified),
    .Error_Unknown_Code        (Error_Unknown_Code),
    .param1                    (param1),
    .param2                    (param2)
  );

  always #5 clk = ~clk;

  function automatic logic [24:0] obs();
    return {decode_valid, is_error_resp, malformed, timeout,
            Error_Invalid_Request, Error_Unsupported_Protocol, Error_Busy,
            Error_Unspecified, Error_Unknown_Code, param1, param2};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents n bytes back to back; rx_last on the final one only if last_on_end.
  task automatic send_msg(input int n, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3,
                          input logic [7:0] b4, input logic [7:0] b5,
                          input bit last_on_end);
    logic [7:0] bytes [6];
    bytes = '{b0, b1, b2, b3, b4, b5};
    not_ready_seen = 1'b0;
    early_dv       = 1'b0;
    for (int i = 0; i < n; i++) begin
      rx_if.rx_byte  = bytes[i];
      rx_if.rx_valid = 1'b1;
      rx_if.rx_last  = last_on_end && (i == n - 1);
      if (rx_if.rx_ready !== 1'b1) not_ready_seen = 1'b1;
      tick();
      if (i < n - 1 && decode_valid !== 1'b0) early_dv = 1'b1;
    end
    rx_if.rx_valid = 1'b0;
    rx_if.rx_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; Enable = 1'b1;
    rx_if.rx_byte = 8'h01; rx_if.rx_valid = 1'b1; rx_if.rx_last = 1'b1;
    tick(); tick();
    n_checks++;
    if (obs() !== 25'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs(), 25'h0);
    end
    n_checks++;
    if (rx_if.rx_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 0", rx_if.rx_ready);
    end
    reset = 1'b0; rx_if.rx_valid = 1'b0; rx_if.rx_last = 1'b0;
    tick();
    n_checks++;
    if (rx_if.rx_ready !== 1'b1 || decode_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: ready %b dv %b expected 1 0", rx_if.rx_ready, decode_valid);
    end
  endtask

  task automatic test_error_codes();
    logic [24:0] exp;
    send_msg(4, 8'h01, 8'h7F, 8'h03, 8'h00, 8'h00, 8'h00, 1'b1);
    n_checks++;
    if (not_ready_seen) begin
      n_fail++; $display("FAIL busy_ready: got ready low expected ready high for every byte");
    end
    exp = {4'b1100, 5'b00100, 8'h03, 8'h00};
    n_checks++;
    if (obs() !== exp) begin
      n_fail++; $display("FAIL busy_report: got %h expected %h", obs(), exp);
    end
    tick();
    exp = {4'b0100, 5'b00100, 8'h03, 8'h00};
    n_checks++;
    if (obs() !== exp) begin
      n_fail++; $display("FAIL busy_hold: got %h expected %h", obs(), exp);
    end

    send_msg(4, 8'h01, 8'h7F, 8'h02, 8'h01, 8'h00, 8'h00, 1'b1);
    exp = {4'b1100, 5'b01000, 8'h02, 8'h01};
    n_checks++;
    if (obs() !== exp) begin
      n_fail++; $display("FAIL unsupported_report: got %h expected %h", obs(), exp);
    end
    tick();

    send_msg(4, 8'h01, 8'h7F, 8'h09, 8'h00, 8'h00, 8'h00, 1'b1);
    exp = {4'b1100, 5'b00001, 8'h09, 8'h00};
    n_checks++;
    if (obs() !== exp) begin
      n_fail++; $display("FAIL unknown_report: got %h expected %h", obs(), exp);
    end
    tick();

    send_msg(4, 8'h01, 8'h7F, 8'h01, 8'h05, 8'h00, 8'h00, 1'b1);
    exp = {4'b1100, 5'b10000, 8'h01, 8'h05};
    n_checks++;
    if (obs() !== exp) begin
      n_fail++; $display("FAIL invalid_report: got %h expected %h", obs(), exp);
    end
    tick();
  endtask

  task automatic test_malformed();
    logic [24:0] exp;
    send_msg(4, 8'h02, 8'h7F, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1);
    exp = {4'b1010, 5'b00000, 8'h01, 8'h00};
    n_checks++;
    if (obs() !== exp) begin
      n_fail++; $display("FAIL version_mismatch: got %h expected %h", obs(), exp);
    end
    tick();

    send_msg(2, 8'h01, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    exp = {4'b1010, 5'b00000, 8'h00, 8'h00};
    n_checks++;
    if (obs() !== exp) begin
      n_fail++; $display("FAIL short_two_bytes: got %h expected %h", obs(), exp);
    end
    tick();

    send_msg(1, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    n_checks++;
    if (obs() !== exp) begin
      n_fail++; $display("FAIL short_one_byte: got %h expected %h", obs(), exp);
    end
    tick();

    send_msg(4, 8'h01, 8'h55, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1);
    exp = {4'b1000, 5'b00000, 8'h01, 8'h00};
    n_checks++;
    if (obs() !== exp) begin
      n_fail++; $display("FAIL non_error_resp: got %h expected %h", obs(), exp);
    end
    tick();
  endtask

  task automatic test_drain();
    logic [24:0] exp;
    send_msg(6, 8'h01, 8'h7F, 8'h01, 8'h00, 8'hAA, 8'hBB, 1'b1);
    n_checks++;
    if (early_dv || not_ready_seen) begin
      n_fail++;
      $display("FAIL drain_handshake: early_dv %b not_ready %b expected 0 0", early_dv, not_ready_seen);
    end
    exp = {4'b1010, 5'b00000, 8'h01, 8'h00};
    n_checks++;
    if (obs() !== exp) begin
      n_fail++; $display("FAIL drain_report: got %h expected %h", obs(), exp);
    end
    tick();
    n_checks++;
    if (decode_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_single_pulse: got %b expected 0", decode_valid);
    end
  endtask

  task automatic test_timeout();
    logic [24:0] exp;
    send_msg(2, 8'h01, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    repeat (15) tick();
    n_checks++;
    if (decode_valid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_early: got dv %b expected 0 after 15 idle cycles", decode_valid);
    end
    tick();
    exp = {4'b1011, 5'b00000, 8'h00, 8'h00};
    n_checks++;
    if (obs() !== exp) begin
      n_fail++; $display("FAIL timeout_report: got %h expected %h", obs(), exp);
    end
    tick();
    n_checks++;
    if (decode_valid !== 1'b0 || rx_if.rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_to_idle: dv %b ready %b expected 0 1", decode_valid, rx_if.rx_ready);
    end
  endtask

  task automatic test_enable_drop();
    logic [24:0] exp;
    send_msg(2, 8'h01, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    Enable = 1'b0;
    tick();
    exp = {4'b0011, 5'b00000, 8'h00, 8'h00};
    n_checks++;
    if (obs() !== exp || rx_if.rx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_drop_hold: got %h ready %b expected %h ready 0", obs(), rx_if.rx_ready, exp);
    end
    Enable = 1'b1;
    tick();
    send_msg(4, 8'h01, 8'h7F, 8'h03, 8'h00, 8'h00, 8'h00, 1'b1);
    exp = {4'b1100, 5'b00100, 8'h03, 8'h00};
    n_checks++;
    if (obs() !== exp) begin
      n_fail++; $display("FAIL enable_restart: got %h expected %h", obs(), exp);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [24:0] exp;
    send_msg(3, 8'h01, 8'h7F, 8'h04, 8'h00, 8'h00, 8'h00, 1'b0);
    reset = 1'b1;
    tick();
    n_checks++;
    if (obs() !== 25'h0 || rx_if.rx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got %h ready %b expected %h ready 0", obs(), rx_if.rx_ready, 25'h0);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (decode_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_no_pulse: got %b expected 0", decode_valid);
    end
    send_msg(4, 8'h01, 8'h7F, 8'h04, 8'h00, 8'h00, 8'h00, 1'b1);
    exp = {4'b1100, 5'b00010, 8'h04, 8'h00};
    n_checks++;
    if (obs() !== exp) begin
      n_fail++; $display("FAIL unspecified_report: got %h expected %h", obs(), exp);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [24:0] exp;
    send_msg(4, 8'h01, 8'h7F, 8'h02, 8'h00, 8'h00, 8'h00, 1'b1);
    // Next message's first byte waits across the REPORT cycle.
    rx_if.rx_byte = 8'h01; rx_if.rx_valid = 1'b1; rx_if.rx_last = 1'b0;
    n_checks++;
    if (rx_if.rx_ready !== 1'b0 || decode_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_report_stall: ready %b dv %b expected 0 1", rx_if.rx_ready, decode_valid);
    end
    tick();
    n_checks++;
    if (rx_if.rx_ready !== 1'b1 || decode_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle_ready: ready %b dv %b expected 1 0", rx_if.rx_ready, decode_valid);
    end
    send_msg(4, 8'h01, 8'h7F, 8'h03, 8'h05, 8'h00, 8'h00, 1'b1);
    exp = {4'b1100, 5'b00100, 8'h03, 8'h05};
    n_checks++;
    if (obs() !== exp) begin
      n_fail++; $display("FAIL b2b_second_report: got %h expected %h", obs(), exp);
    end
    tick();
  endtask

  initial begin
    reset = 1'b1; Enable = 1'b0;
    rx_if.rx_byte = 8'h00; rx_if.rx_valid = 1'b0; rx_if.rx_last = 1'b0;
    test_reset();
    test_error_codes();
    test_malformed();
    test_drain();
    test_timeout();
    test_enable_drop();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/error_response_decoder.md
ERROR_RESPONSE_DECODER -- requirements
Module: error_response_decoder

Interface
REQ-001 SHALL have parameter PROTOCOL_VERSION, default 8'h01: expected header byte 0.
REQ-002 SHALL have parameter ERROR_RESP_CMD, default 8'h7F: header byte 1 value identifying an error response.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000: maximum idle cycles between bytes inside a message.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port Enable  input  1  decoder active; low forces IDLE.
REQ-007 SHALL have port rx_byte  input  8  received message byte, header byte 0 first.
REQ-008 SHALL have port rx_valid  input  1  rx_byte valid this cycle.
REQ-009 SHALL have port rx_last  input  1  qualifies rx_byte as the final byte of the message.
REQ-010 SHALL have port rx_ready  output  1  decoder accepts a byte this cycle.
REQ-011 SHALL have port decode_valid  output  1  one-cycle pulse: result outputs updated.
REQ-012 SHALL have ports is_error_resp, malformed, timeout  output  1 each  message classification.
REQ-013 SHALL have ports Error_Invalid_Request, Error_Unsupported_Protocol, Error_Busy, Error_Unspecified, Error_Unknown_Code  output  1 each  decoded error code.
REQ-014 SHALL have ports param1, param2  output  8 each  captured header bytes 2 and 3.

Function
REQ-015 SHALL accept a byte when rx_valid && rx_ready; rx_ready = Enable && state != REPORT.
REQ-016 SHALL implement states IDLE, B1, B2, B3, DRAIN, REPORT; byte accepted in IDLE/B1/B2/B3 advances to B1/B2/B3/DRAIN respectively.
REQ-017 SHALL capture byte 0 into a version-mismatch flag (set if != PROTOCOL_VERSION), byte 1 into a not-error flag (set if != ERROR_RESP_CMD), byte 2 into param1, byte 3 into param2.
REQ-018 SHALL go to REPORT on an accepted byte with rx_last in IDLE/B1/B2 (short message: malformed=1) or in B3 (complete header).
REQ-019 SHALL, on byte 3 accepted without rx_last, enter DRAIN, mark malformed (payload not allowed), discard bytes until one with rx_last, then enter REPORT.
REQ-020 SHALL count cycles without an accepted byte in B1/B2/B3/DRAIN; counter clears on each accepted byte and on entering IDLE; reaching TIMEOUT_CYCLES enters REPORT with timeout=1, malformed=1.
REQ-021 SHALL in REPORT assert decode_valid for exactly one cycle, then return to IDLE; decode_valid appears the cycle after the final byte (or timeout) is taken.
REQ-022 SHALL set is_error_resp=1 only if header complete, version matched and byte 1 == ERROR_RESP_CMD.
REQ-023 SHALL, when is_error_resp=1, assert exactly one error flag: param1 01->Invalid_Request, 02->Unsupported_Protocol, 03->Busy, 04->Unspecified, other->Unknown_Code; all error flags 0 otherwise.
REQ-024 SHALL set malformed=1 also on version mismatch; malformed and is_error_resp are never both 1.
REQ-025 SHALL hold all result outputs stable from REPORT until the next REPORT or reset.
REQ-026 SHALL, when Enable falls mid-message, return to IDLE next cycle without a decode_valid pulse, results unchanged.
REQ-027 SHALL give reset priority over Enable, rx_valid and timeout in the same cycle.

Reset
REQ-028 SHALL on reset enter IDLE, clear timeout counter and internal flags.
REQ-029 SHALL drive rx_ready=0, decode_valid=0, all flags=0, param1=param2=8'h00 the cycle after reset is sampled high.
REQ-030 SHALL abandon any partial message on reset with no decode_valid pulse.

Verification
REQ-031 Bytes 01,7F,03,00 with rx_last on last -> next cycle decode_valid=1, is_error_resp=1, Error_Busy=1, param2=00.
REQ-032 Bytes 01,7F,02,01 -> Error_Unsupported_Protocol=1, param2=01; bytes 01,7F,09,00 -> Error_Unknown_Code=1.
REQ-033 Bytes 02,7F,01,00 -> malformed=1, is_error_resp=0, all error flags 0; bytes 01,7F with rx_last on 7F -> malformed=1.
REQ-034 Bytes 01,7F,01,00,AA,BB (rx_last on BB) -> DRAIN consumes 2 bytes, malformed=1, decode_valid once after BB.
REQ-035 Bytes 01,7F then no rx_valid for TIMEOUT_CYCLES -> timeout=1, malformed=1, decode_valid pulse, back to IDLE.
REQ-036 Reset asserted after byte 2 -> outputs 0, no decode_valid; following 01,7F,04,00 -> Error_Unspecified=1.
